// File: rtl/pheap_root_ctl_if.sv
// -----------------------------------------------------------------------------
// pheap_root_ctl_if
// Bundles every non-clock/reset signal of the heap root controller.
//   Command channel : start, op, in -> ready
//   Child read      : raddr_bot -> r_bot_{l,r}_{pri,act,cap}
//   Result          : out_valid, out, err
//   Forward channel : fwd_valid, fwd_op, fwd_val, fwd_pos <- fwd_ready
//   Status          : count, empty, full
// master = upstream requester plus level-2 storage model; slave = controller.
// -----------------------------------------------------------------------------
interface pheap_root_ctl_if #(
   parameter int PRI_W  = 32,
   parameter int LEVELS = 4
);
   logic              start;
   logic [1:0]        op;
   logic [PRI_W-1:0]  in;
   logic              ready;
   logic              raddr_bot;
   logic [PRI_W-1:0]  r_bot_l_pri;
   logic [PRI_W-1:0]  r_bot_r_pri;
   logic              r_bot_l_act;
   logic              r_bot_r_act;
   logic [LEVELS-1:0] r_bot_l_cap;
   logic [LEVELS-1:0] r_bot_r_cap;
   logic              out_valid;
   logic [PRI_W-1:0]  out;
   logic              err;
   logic              fwd_valid;
   logic              fwd_ready;
   logic [1:0]        fwd_op;
   logic [PRI_W-1:0]  fwd_val;
   logic              fwd_pos;
   logic [LEVELS-1:0] count;
   logic              empty;
   logic              full;

   modport master (
      output start, op, in,
      output r_bot_l_pri, r_bot_r_pri, r_bot_l_act, r_bot_r_act,
      output r_bot_l_cap, r_bot_r_cap, fwd_ready,
      input  ready, raddr_bot, out_valid, out, err,
      input  fwd_valid, fwd_op, fwd_val, fwd_pos, count, empty, full
   );

   modport slave (
      input  start, op, in,
      input  r_bot_l_pri, r_bot_r_pri, r_bot_l_act, r_bot_r_act,
      input  r_bot_l_cap, r_bot_r_cap, fwd_ready,
      output ready, raddr_bot, out_valid, out, err,
      output fwd_valid, fwd_op, fwd_val, fwd_pos, count, empty, full
   );
endinterface

// File: rtl/pheap_root_ctl.sv
// -----------------------------------------------------------------------------
// pheap_root_ctl
// Level-1 (root) controller of a pipelined heap priority queue. Holds the root
// entry and the global occupancy, executes ENQ / DEQ / REPLACE commands, reads
// the two level-2 children and forwards the follow-up command to level 2.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pheap_root_ctl_if.slave (command, child read, result, forward, status)
//   hwm, err_cnt - occupancy high-water mark and saturating error counter,
//                  present only when PHEAP_STATS_EN is defined
//
// Optional feature macro: PHEAP_STATS_EN
// -----------------------------------------------------------------------------
module pheap_root_ctl #(
   parameter int PRI_W    = 32,
   parameter int LEVELS   = 4,
   parameter int MIN_HEAP = 0
) (
   input  logic              clk,
   input  logic              rst,
   pheap_root_ctl_if.slave   bus
`ifdef PHEAP_STATS_EN
   ,
   output logic [LEVELS-1:0] hwm,
   output logic [15:0]       err_cnt
`endif
);

   localparam logic [1:0] OP_ENQ = 2'd0;
   localparam logic [1:0] OP_DEQ = 2'd1;
   localparam logic [1:0] OP_REP = 2'd2;

   localparam logic [LEVELS-1:0] CNT_FULL = '1;
   localparam logic [LEVELS-1:0] CNT_ZERO = '0;
   localparam logic [LEVELS-1:0] CNT_ONE  = LEVELS'(1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_FWD} state_t;

   state_t            r_state;
   state_t            w_next;

   logic [1:0]        r_op;
   logic [PRI_W-1:0]  r_in;
   logic [PRI_W-1:0]  r_root;
   logic              r_root_act;
   logic [LEVELS-1:0] r_count;
   logic [1:0]        r_fwd_op;
   logic [PRI_W-1:0]  r_fwd_val;
   logic              r_fwd_pos;

   logic              w_any_act;
   logic              w_best_r;
   logic [PRI_W-1:0]  w_best_pri;
   logic              w_enq_pos;

   logic              w_err;
   logic [PRI_W-1:0]  w_out;
   logic [PRI_W-1:0]  w_root_nxt;
   logic              w_root_act_nxt;
   logic [LEVELS-1:0] w_count_nxt;
   logic              w_do_fwd;
   logic [1:0]        w_fwd_op_nxt;
   logic [PRI_W-1:0]  w_fwd_val_nxt;
   logic              w_fwd_pos_nxt;

   // Heap ordering: true when a belongs closer to the root than b.
   function automatic logic beats(input logic [PRI_W-1:0] a, input logic [PRI_W-1:0] b);
      if (MIN_HEAP != 0) return (a < b);
      else               return (a > b);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) return v;
      else               return v + 16'd1;
   endfunction

   // Best child: the lone active child, else the one that wins; ties go left.
   assign w_any_act  = bus.r_bot_l_act | bus.r_bot_r_act;
   assign w_best_r   = bus.r_bot_r_act &
                       (!bus.r_bot_l_act || beats(bus.r_bot_r_pri, bus.r_bot_l_pri));
   assign w_best_pri = w_best_r ? bus.r_bot_r_pri : bus.r_bot_l_pri;

   // ENQ target: roomier subtree, ties left, and never a subtree with no room.
   assign w_enq_pos  = (bus.r_bot_l_cap == CNT_ZERO) ||
                       (bus.r_bot_r_cap > bus.r_bot_l_cap);

   // Command evaluation used during EXEC; child data is valid in this cycle.
   always_comb begin
      w_err          = 1'b0;
      w_out          = '0;
      w_root_nxt     = r_root;
      w_root_act_nxt = r_root_act;
      w_count_nxt    = r_count;
      w_do_fwd       = 1'b0;
      w_fwd_op_nxt   = r_op;
      w_fwd_val_nxt  = '0;
      w_fwd_pos_nxt  = 1'b0;
      case (r_op)
         OP_ENQ: begin
            if (r_count == CNT_FULL) begin
               w_err = 1'b1;
            end else begin
               w_count_nxt = r_count + CNT_ONE;
               if (!r_root_act) begin
                  w_root_nxt     = r_in;
                  w_root_act_nxt = 1'b1;
               end else begin
                  w_do_fwd      = 1'b1;
                  w_fwd_pos_nxt = w_enq_pos;
                  // Equal values keep the existing root and push the newcomer down.
                  if (beats(r_in, r_root)) begin
                     w_root_nxt    = r_in;
                     w_fwd_val_nxt = r_root;
                  end else begin
                     w_fwd_val_nxt = r_in;
                  end
               end
            end
         end
         OP_DEQ: begin
            if (r_count == CNT_ZERO) begin
               w_err = 1'b1;
            end else begin
               w_out       = r_root;
               w_count_nxt = r_count - CNT_ONE;
               if (!w_any_act) begin
                  w_root_nxt     = '0;
                  w_root_act_nxt = 1'b0;
               end else begin
                  w_root_nxt    = w_best_pri;
                  w_do_fwd      = 1'b1;
                  w_fwd_pos_nxt = w_best_r;
               end
            end
         end
         OP_REP: begin
            if (r_count == CNT_ZERO) begin
               w_err = 1'b1;
            end else begin
               w_out = r_root;
               if (!w_any_act || !beats(w_best_pri, r_in)) begin
                  w_root_nxt = r_in;
               end else begin
                  w_root_nxt    = w_best_pri;
                  w_do_fwd      = 1'b1;
                  w_fwd_val_nxt = r_in;
                  w_fwd_pos_nxt = w_best_r;
               end
            end
         end
         default: w_err = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.start) w_next = S_READ;
         S_READ: w_next = S_EXEC;
         S_EXEC: w_next = (w_err || !w_do_fwd) ? S_IDLE : S_FWD;
         S_FWD:  if (bus.fwd_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state; fwd_valid falls as soon as rst clears the state.
   always_comb begin
      bus.ready     = (r_state == S_IDLE);
      bus.raddr_bot = (r_state == S_READ);
      bus.out_valid = (r_state == S_EXEC);
      bus.out       = (r_state == S_EXEC) ? w_out : '0;
      bus.err       = (r_state == S_EXEC) && w_err;
      bus.fwd_valid = (r_state == S_FWD);
      bus.fwd_op    = r_fwd_op;
      bus.fwd_val   = r_fwd_val;
      bus.fwd_pos   = r_fwd_pos;
      bus.count     = r_count;
      bus.empty     = (r_count == CNT_ZERO);
      bus.full      = (r_count == CNT_FULL);
   end

   // Command latch, root / occupancy update and forward payload
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op       <= '0;
         r_in       <= '0;
         r_root     <= '0;
         r_root_act <= 1'b0;
         r_count    <= '0;
         r_fwd_op   <= '0;
         r_fwd_val  <= '0;
         r_fwd_pos  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_op <= bus.op;
            r_in <= bus.in;
         end
         if (r_state == S_EXEC && !w_err) begin
            r_root     <= w_root_nxt;
            r_root_act <= w_root_act_nxt;
            r_count    <= w_count_nxt;
            if (w_do_fwd) begin
               r_fwd_op  <= w_fwd_op_nxt;
               r_fwd_val <= w_fwd_val_nxt;
               r_fwd_pos <= w_fwd_pos_nxt;
            end
         end
      end
   end

`ifdef PHEAP_STATS_EN
   logic [LEVELS-1:0] r_hwm;
   logic [15:0]       r_err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hwm     <= '0;
         r_err_cnt <= '0;
      end else begin
         if (r_count > r_hwm) r_hwm <= r_count;
         if (bus.err)         r_err_cnt <= sat_inc16(r_err_cnt);
      end
   end

   assign hwm     = r_hwm;
   assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/pheap_root_ctl.md
Name: pheap_root_ctl

Overview:
- Parametrised level-1 (root) controller for the pipelined heap priority queue.
- Holds the root entry and global occupancy, and accepts ENQ/DEQ/REPLACE commands through a start/ready handshake.
- Reads the two level-2 child entries, returns the popped value, and forwards a command to level 2 through a valid/ready channel with backpressure.
- Supports max-heap or min-heap ordering, selected by parameter.

Parameters:
- PRI_W, 32, priority value width in bits.
- LEVELS, 4, heap depth; capacity is 2^LEVELS-1 entries.
- MIN_HEAP, 0, 0 = largest value at root, 1 = smallest value at root.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  command request; accepted when start && ready.
- op  in  2  command: 0 ENQ, 1 DEQ, 2 REPLACE, 3 reserved (treated as error).
- in  in  PRI_W  value for ENQ/REPLACE.
- ready  out  1  controller idle and able to accept a command.
- raddr_bot  out  1  level-2 read enable, asserted in READ state.
- r_bot_l_pri, r_bot_r_pri  in  PRI_W  left/right child priority.
- r_bot_l_act, r_bot_r_act  in  1  child entry valid.
- r_bot_l_cap, r_bot_r_cap  in  LEVELS  free slots in each child subtree.
- out_valid  out  1  one-cycle pulse: out/err valid.
- out  out  PRI_W  popped value (DEQ/REPLACE); 0 otherwise.
- err  out  1  with out_valid: illegal op, DEQ/REPLACE on empty, or ENQ on full.
- fwd_valid  out  1  command pending for level 2.
- fwd_ready  in  1  level 2 accepts; transfer on fwd_valid && fwd_ready.
- fwd_op  out  2  forwarded op.
- fwd_val  out  PRI_W  forwarded value.
- fwd_pos  out  1  target child: 0 left, 1 right.
- count  out  LEVELS  occupied entries.
- empty, full  out  1  count==0 / count==2^LEVELS-1.

Behaviour:
- Reset (async):
  - state=IDLE, root inactive, root value 0, count 0.
  - ready=1, out_valid=0, out=0, err=0, fwd_valid=0, fwd_* = 0, raddr_bot=0.
  - A reset in any state aborts the operation and drops fwd_valid immediately.
- "beats(a,b)": a>b if MIN_HEAP=0, a<b if MIN_HEAP=1.
- Best child:
  - If only one child is active, that child.
  - If both are active, the one that beats the other; on a tie, left.
- FSM states: IDLE, READ, EXEC, FWD.
- IDLE:
  - ready=1.
  - On start, latch op/in and go to READ.
- READ:
  - raddr_bot=1; child data is valid in the following cycle.
  - Go to EXEC.
- EXEC (single cycle):
  - Root and count are written at the end of this cycle.
  - out_valid pulses in this cycle, giving latency of 2 cycles from the accept edge.
  - Errors (illegal op, DEQ/REPLACE on empty, ENQ on full): err=1, out=0, no state change, go to IDLE.
- ENQ, root inactive:
  - root=in, active=1.
  - Go to IDLE.
- ENQ, root active:
  - Root keeps the winner of beats(in,root); on equality the root is kept.
  - The loser is forwarded as ENQ.
  - fwd_pos = child with larger cap; on a tie, left; a child with cap 0 is never chosen.
  - Go to FWD.
- ENQ completion: count+1 in both cases.
- DEQ:
  - out=root.
  - If no child is active, root becomes inactive with value 0; go to IDLE.
  - Otherwise root=best child value and DEQ is forwarded to fwd_pos=best child; go to FWD.
  - count-1.
- REPLACE:
  - out=root.
  - If no child is active, or in is not beaten by the best child, root=in; go to IDLE.
  - Otherwise root=best child and REPLACE(in) is forwarded to the best child; go to FWD.
  - count unchanged.
- FWD:
  - fwd_valid=1, with fwd_* held stable until fwd_ready.
  - On handshake go to IDLE; ready returns to 1 the next cycle.
  - start is ignored while ready=0.
- Arithmetic: count is LEVELS bits unsigned and never wraps, guaranteed by the error checks.

Optional Feature:
- Macro PHEAP_STATS_EN.
- When defined:
  - Adds output hwm[LEVELS-1:0], the occupancy high-water mark, updated when count exceeds it and cleared by rst.
  - Adds output err_cnt[15:0], which increments on each err pulse and saturates at 16'hFFFF.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset, ENQ 5 -> out_valid at cycle 2 with out=0, err=0, count=1, fwd_valid never asserted.
- MIN_HEAP=0, root=5, ENQ 9, children inactive with caps 3/3 -> root=9, fwd_op=ENQ, fwd_val=5, fwd_pos=0; holding fwd_ready=0 for 3 cycles keeps fwd_* stable and ready=0.
- Root=9, children 7/8 active, DEQ -> out=9, root=8, fwd_op=DEQ, fwd_pos=1, count decrements.
- REPLACE 10 with root=9 and best child 8 -> out=9, root=10, no forward; REPLACE 1 -> root=8, fwd REPLACE 1 to the right child.
- DEQ on empty -> err=1, out=0, count=0; ENQ at count=15 (LEVELS=4) -> err=1, root unchanged.
- Assert rst while in FWD -> fwd_valid=0, count=0, and ready=1 in the same cycle, without waiting for a clock edge.
